// File: rtl/alu_defs.sv
// Opcode constants shared by the alu, its command sequencer and benches.
package alu_defs;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] ADD = 2'd0;
  localparam logic [OP_W-1:0] SUB = 2'd1;
  localparam logic [OP_W-1:0] MUL = 2'd2;
  localparam logic [OP_W-1:0] DIV = 2'd3;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; pointers carry one wrap bit for full/empty.
module cmd_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational alu: buffers commands, drives the
// alu from registers one at a time and returns results with a div0 flag.
module alu_cmd_sequencer
  import alu_defs::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [1:0]        cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_op,
  output logic              rsp_err,
  output logic              busy
);

  localparam int ENT_W = 2*DATA_W + OP_W;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            state;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic [OP_W-1:0]   head_op;

  // Full blocks new commands even on a pop cycle: no pass-through.
  assign cmd_ready = !rst && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE) || !fifo_empty;

  assign {head_op, head_a, head_b} = head;

  cmd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_op, cmd_a, cmd_b}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            alu_a  <= head_a;
            alu_b  <= head_b;
            alu_op <= head_op;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // The alu does not flag div0; substitute all-ones here.
          if (alu_op == DIV && alu_b == '0) begin
            rsp_data <= '1;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= alu_out;
            rsp_err  <= 1'b0;
          end
          rsp_op    <= alu_op;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural alu
// and a queue-based response scoreboard.
module tb_alu_cmd_sequencer;
  import alu_defs::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [1:0]    cmd_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_op;
  logic          rsp_err;
  logic          busy;

  alu_cmd_sequencer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_op    (rsp_op),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the alu; div0 yields a junk value that must be ignored.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      ADD: alu_out = alu_a + alu_b;
      SUB: alu_out = alu_a - alu_b;
      MUL: alu_out = alu_a * alu_b;
      DIV: alu_out = (alu_b == 0) ? 8'h5A : alu_a / alu_b;
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic [7:0] d;
    logic [1:0] op;
    logic       err;
  } rsp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] exp_d;
    logic       exp_err;
  } vec_t;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_rsp = 0;
  int   last_acc_edge = 0;
  rsp_t exp_q[$];
  int   rsp_cyc[$];
  rsp_t last_rsp;
  logic held = 1'b0;
  rsp_t hold_v;

  function automatic rsp_t model(input logic [7:0] a,
                                 input logic [7:0] b,
                                 input logic [1:0] op);
    rsp_t r;
    int   ia;
    int   ib;
    ia = int'(a);
    ib = int'(b);
    r.op  = op;
    r.err = 1'b0;
    r.d   = '0;
    if (op == ADD) r.d = 8'((ia + ib) % 256);
    else if (op == SUB) r.d = 8'((ia - ib + 256) % 256);
    else if (op == MUL) r.d = 8'((ia * ib) % 256);
    else if (ib == 0) begin
      r.d   = 8'd255;
      r.err = 1'b1;
    end else r.d = 8'(ia / ib);
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic step();
    rsp_t e;
    if (!rst && cmd_valid && cmd_ready) begin
      exp_q.push_back(model(cmd_a, cmd_b, cmd_op));
      n_acc++;
      last_acc_edge = cyc + 1;
    end
    if (held) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, hold_v.d);
      chk("hold_op", rsp_op, hold_v.op);
      chk("hold_err", rsp_err, hold_v.err);
    end
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      rsp_cyc.push_back(cyc);
      last_rsp.d   = rsp_data;
      last_rsp.op  = rsp_op;
      last_rsp.err = rsp_err;
      if (exp_q.size() == 0) chk("spurious_rsp", rsp_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_op", rsp_op, e.op);
        chk("rsp_err", rsp_err, e.err);
      end
    end
    held     = rsp_valid && !rsp_ready;
    hold_v.d   = rsp_data;
    hold_v.op  = rsp_op;
    hold_v.err = rsp_err;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_cmd(input logic [7:0] a,
                          input logic [7:0] b,
                          input logic [1:0] op);
    logic ok;
    ok = 1'b0;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    if (!ok) chk("push_timeout", cmd_ready, 1);
  endtask

  task automatic wait_idle(input int max);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      if (exp_q.size() == 0 && !busy && !rsp_valid) done = 1'b1;
      else step();
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic push_rand();
    push_cmd(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];
  int   n0;
  int   r0;
  int   a0;
  logic got;

  initial begin
    vecs[0] = '{8'd5,   8'd4,  ADD, 8'd9,   1'b0};
    vecs[1] = '{8'd4,   8'd5,  SUB, 8'd255, 1'b0};
    vecs[2] = '{8'd20,  8'd20, MUL, 8'd144, 1'b0};
    vecs[3] = '{8'd5,   8'd4,  DIV, 8'd1,   1'b0};
    vecs[4] = '{8'd7,   8'd0,  DIV, 8'hFF,  1'b1};
    vecs[5] = '{8'd1,   8'd1,  ADD, 8'd2,   1'b0};
    vecs[6] = '{8'd255, 8'd1,  ADD, 8'd0,   1'b0};
    vecs[7] = '{8'd16,  8'd16, MUL, 8'd0,   1'b0};
    vecs[8] = '{8'd200, 8'd7,  DIV, 8'd28,  1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_op", rsp_op, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready", cmd_ready, 1);

    rsp_ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      n0 = n_rsp;
      push_cmd(vecs[v].a, vecs[v].b, vecs[v].op);
      for (int i = 0; i < 20 && n_rsp == n0; i++) step();
      if (n_rsp == n0) chk("tbl_timeout", n_rsp, n0 + 1);
      else begin
        chk("tbl_latency", rsp_cyc[rsp_cyc.size()-1] - last_acc_edge, 2);
        chk("tbl_data", last_rsp.d, vecs[v].exp_d);
        chk("tbl_op", last_rsp.op, vecs[v].op);
        chk("tbl_err", last_rsp.err, vecs[v].exp_err);
      end
      wait_idle(20);
    end

    n0 = rsp_cyc.size();
    push_cmd(8'd4, 8'd5, SUB);
    push_cmd(8'd20, 8'd20, MUL);
    push_cmd(8'd5, 8'd4, DIV);
    wait_idle(40);
    if (rsp_cyc.size() < n0 + 3) chk("burst_count", rsp_cyc.size() - n0, 3);
    else begin
      chk("burst_gap1", rsp_cyc[n0+1] - rsp_cyc[n0], 3);
      chk("burst_gap2", rsp_cyc[n0+2] - rsp_cyc[n0+1], 3);
    end

    rsp_ready = 1'b0;
    a0 = n_acc;
    r0 = n_rsp;
    for (int i = 0; i < 5; i++) push_rand();
    chk("cap_ready_low", cmd_ready, 0);
    cmd_a = 8'd9;
    cmd_b = 8'd3;
    cmd_op = SUB;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("cap_blocked", cmd_ready, 0);
      step();
    end
    chk("cap_count", n_acc - a0, 5);
    rsp_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      got = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    chk("cap_sixth_acc", n_acc - a0, 6);
    wait_idle(60);
    chk("cap_rsps", n_rsp - r0, 6);

    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_rand();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    held = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b1;
    r0 = n_rsp;
    for (int i = 0; i < 10; i++) begin
      chk("post_rst_quiet", rsp_valid, 0);
      step();
    end
    chk("post_rst_rsps", n_rsp - r0, 0);

    rsp_ready = 1'b0;
    r0 = n_rsp;
    for (int i = 0; i < 4; i++) push_rand();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("pp_ready_before", cmd_ready, 1);
    push_cmd(8'd33, 8'd11, DIV);
    chk("pp_ready_after", cmd_ready, 1);
    push_cmd(8'd8, 8'd0, DIV);
    chk("pp_now_full", cmd_ready, 0);
    rsp_ready = 1'b1;
    wait_idle(80);
    chk("pp_rsps", n_rsp - r0, 6);

    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a = 8'($urandom);
      cmd_b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      cmd_op = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(100);
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the combinational `alu` block. It accepts ALU commands (operands plus opcode) on a valid/ready interface and buffers them in a small FIFO. It drives the ALU inputs one command at a time from registers, captures the ALU result, and presents it on a valid/ready response interface. It also detects divide-by-zero, which the ALU itself does not flag.

Parameters:
DATA_W, 8, operand/result width; must match the ALU data width.
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_a  in  DATA_W  operand A.
cmd_b  in  DATA_W  operand B.
cmd_op  in  2  opcode: ADD/SUB/MUL/DIV.
alu_a  out  DATA_W  to ALU data_a.
alu_b  out  DATA_W  to ALU data_b.
alu_op  out  2  to ALU opcode.
alu_out  in  DATA_W  ALU result (combinational).
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_data  out  DATA_W  result.
rsp_op  out  2  opcode of this result.
rsp_err  out  1  divide-by-zero flag.
busy  out  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; FSM in IDLE.
  - alu_a, alu_b, alu_op, rsp_data, rsp_op, rsp_err, rsp_valid, busy all 0.
  - cmd_ready forced 0 while rst=1.
- Command accept:
  - cmd_ready = !fifo_full (when rst=0). Push occurs on an edge where cmd_valid && cmd_ready.
  - There is no bypass path; every command passes through the FIFO.
  - A push and a pop in the same cycle are both honoured. When the FIFO is full, cmd_ready stays 0 even if a pop occurs that cycle; there is no pass-through.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head into alu_a/alu_b/alu_op and go to EXEC. Otherwise stay. alu_* keep their last values.
  - EXEC: one cycle in which the ALU settles. At the end of the cycle:
    - rsp_data <= alu_out, rsp_op <= alu_op, rsp_err <= 0, rsp_valid <= 1; go to RESP.
    - Exception: if alu_op==DIV and alu_b==0, then rsp_data <= all-ones and rsp_err <= 1 (alu_out is ignored).
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On an rsp_ready edge, rsp_valid <= 0 and go to IDLE.
- Latency and throughput:
  - Command accepted at edge E0 → popped at E1 → rsp_valid high after E2. The minimum is 2 cycles.
  - Issue rate is at most one command per 3 cycles (IDLE/EXEC/RESP); back-to-back responses are 3 cycles apart with rsp_ready=1.
  - Responses are produced in command order.
- Arithmetic: results are truncated to DATA_W, exactly as the ALU produces them. SUB wraps modulo 2^DATA_W; MUL keeps the low DATA_W bits.
- Capacity: with rsp_ready=0, up to FIFO_DEPTH+1 commands are accepted (one in the FSM plus FIFO_DEPTH in the FIFO).
- Reset mid-operation: any state or FIFO contents are discarded immediately. No response is emitted after rst deasserts unless new commands arrive.
- busy = (state != IDLE) || !fifo_empty.

Decomposition:
- Shared header/package alu_defs: the opcode constants ADD=2'd0, SUB=2'd1, MUL=2'd2, DIV=2'd3, and the opcode width. These are used by alu, alu_cmd_sequencer and the benches.
- FSM state encoding stays local to the module.
- One sub-module: cmd_fifo, a synchronous FIFO parameterised by width (2*DATA_W+2) and FIFO_DEPTH. It has push/pop/full/empty signals and an async active-high reset.

Test Plan:
1. ADD: push (5,4,ADD) with rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_data=9, rsp_op=ADD, rsp_err=0.
2. Wrap and truncation: (4,5,SUB)→255; (20,20,MUL)→144; (5,4,DIV)→1. Responses arrive in order, 3 cycles apart.
3. Divide by zero: push (7,0,DIV) → rsp_err=1, rsp_data=8'hFF regardless of alu_out; the next command (1,1,ADD) → 2 with rsp_err=0.
4. Backpressure: hold rsp_ready=0 and push 6 commands → cmd_ready drops after the 5th accept. While rsp_ready=0, rsp_* stay stable. Releasing rsp_ready yields 5 responses in order, and the 6th is then accepted.
5. Reset mid-operation: 3 commands queued, assert rst during EXEC → rsp_valid=0, busy=0, cmd_ready=0 immediately. After release, cmd_ready=1 and no response appears for 10 cycles.
6. Simultaneous push/pop: with the FIFO at DEPTH-1 entries, push while IDLE pops → occupancy unchanged, cmd_ready stays 1, and no command is lost or duplicated (scoreboard check).
